// File: rtl/output_display_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: hex segment table,
// segment bit positions, load handshake states and counter width helpers.
package output_display_scanner_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F (lowercase b and d).
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    LOAD_EMPTY,
    LOAD_PENDING
  } load_state_e;

  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_digits);
    return count_width(num_digits);
  endfunction

  function automatic int unsigned presc_width(input int unsigned scan_div);
    return count_width(scan_div);
  endfunction

endpackage

// File: rtl/output_display_scanner_if.sv
// Load handshake and display drive bundle between an upstream producer (master)
// and the scanner (slave).
interface output_display_scanner_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic                    blank;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output load_valid, load_data, load_dp, blank,
    input  load_ready, seg, dp, digit_en, frame_done
  );

  modport slave (
    input  load_valid, load_data, load_dp, blank,
    output load_ready, seg, dp, digit_en, frame_done
  );

endinterface

// File: rtl/output_display_scanner_seg7_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern; polarity and
// registering are left to the instantiating level.
module seg7_hex_decoder
  import output_display_scanner_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/output_display_scanner.sv
// Multiplexed 7-segment scanner: shadow-buffered hex word promoted at frame
// boundaries, per-digit slots with leading dead time, registered drive outputs.
module output_display_scanner
  import output_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  output_display_scanner_if.slave bus
);

  if (NUM_DIGITS < 2) begin : g_bad_num_digits
    $error("output_display_scanner: NUM_DIGITS must be at least 2");
  end
  if (SCAN_DIV <= DEAD_CYCLES + 1) begin : g_bad_scan_div
    $error("output_display_scanner: SCAN_DIV must exceed DEAD_CYCLES+1");
  end

  localparam int IDX_W   = idx_width(NUM_DIGITS);
  localparam int PRESC_W = presc_width(SCAN_DIV);

  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0]    LIT_START  = PRESC_W'(DEAD_CYCLES);
  localparam logic [SEG_W-1:0]      SEG_POL    = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIGIT_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PRESC_W-1:0] presc;
  logic [IDX_W-1:0]   idx;
  logic               presc_term;
  logic               frame_edge;

  load_state_e state;
  load_state_e state_next;
  logic        load_ready_int;
  logic        accept;
  logic        promote;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic [SEG_W-1:0]      seg_hi;
  logic [NUM_DIGITS-1:0] digit_sel;

  logic [SEG_W-1:0]      seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] digit_en_q;
  logic                  frame_done_q;

  assign presc_term = (presc == PRESC_LAST);
  assign frame_edge = presc_term && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc_term) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A pending word blocks new accepts, so promotion and accept never collide.
  always_comb begin
    state_next     = state;
    load_ready_int = 1'b0;
    accept         = 1'b0;
    promote        = 1'b0;
    case (state)
      LOAD_EMPTY: begin
        load_ready_int = !reset;
        accept         = bus.load_valid && load_ready_int;
        if (accept) begin
          state_next = LOAD_PENDING;
        end
      end
      LOAD_PENDING: begin
        promote = frame_edge;
        if (frame_edge) begin
          state_next = LOAD_EMPTY;
        end
      end
      default: begin
        state_next = LOAD_EMPTY;
      end
    endcase
  end

  assign bus.load_ready = load_ready_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
    end else begin
      if (accept) begin
        shadow_data <= bus.load_data;
        shadow_dp   <= bus.load_dp;
      end
      if (promote) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
      end
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    digit_sel  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble   = active_data[i*4 +: 4];
        cur_dp       = active_dp[i];
        digit_sel[i] = (presc >= LIT_START) && !bus.blank;
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (seg_hi)
  );

  // Polarity is folded in here so reset drives every output to its off level.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= SEG_POL;
      dp_q         <= ACTIVE_LOW;
      digit_en_q   <= DIGIT_POL;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_hi ^ SEG_POL;
      dp_q         <= cur_dp ^ ACTIVE_LOW;
      digit_en_q   <= digit_sel ^ DIGIT_POL;
      frame_done_q <= frame_edge;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;

endmodule
